// File: rtl/gb_cpu_mcycle_sequencer.sv
// ---------------------------------------------------------------------------
// gb_cpu_mcycle_sequencer
//
// Instruction register and T-cycle/M-cycle timing for a Game Boy style core.
// It walks the decoder's M-cycle schedule and shortens a conditional
// instruction when its condition turns out false. It also handles the 0xCB
// prefix fetch, the opcode fetch that overlaps each instruction's last
// M-cycle, and HALT/wake.
//
// Ports:
//   clk                 system clock, one T-cycle per period
//   reset               synchronous, active-high
//   data_in[7:0]        memory read bus, valid at T3 of a fetch M-cycle
//   sched_len[2:0]      M-cycle count of the current opcode (condition true)
//   sched_cond_mcycle   M-cycle whose T3 samples cond_met (0 = unconditional)
//   sched_short_len     M-cycle count when the condition is false
//   cond_met            flag-condition result from execute
//   halt_req            execute requests HALT (sampled at the last T3)
//   wake                interrupt pending
//   opcode[7:0]         instruction register, to decoder
//   cb_prefix           opcode is 0xCB-prefixed, to decoder
//   m_cycle[2:0]        M-cycle index within the instruction
//   t_cycle[1:0]        T-cycle within the M-cycle
//   fetch               this M-cycle ends with an opcode fetch
//   instr_done          one-clk pulse at T3 of the last M-cycle
//   halted              core is in HALT
// ---------------------------------------------------------------------------
module gb_cpu_mcycle_sequencer #(
    parameter int MAX_MCYCLES   = 6,
    parameter int TCYCLES_PER_M = 4   // must fit the 2-bit t_cycle counter
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [2:0] sched_len,
    input  logic [2:0] sched_cond_mcycle,
    input  logic [2:0] sched_short_len,
    input  logic       cond_met,
    input  logic       halt_req,
    input  logic       wake,
    output logic [7:0] opcode,
    output logic       cb_prefix,
    output logic [2:0] m_cycle,
    output logic [1:0] t_cycle,
    output logic       fetch,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PREFIX,
        ST_HALT,
        ST_WAKE
    } state_e;

    localparam logic [1:0] T_LAST = 2'(TCYCLES_PER_M - 1);
    localparam logic [3:0] MAX_L  = 4'(MAX_MCYCLES);
    localparam logic [7:0] CB_OP  = 8'hCB;

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic       cb_prefix_q, cb_prefix_d;
    logic [2:0] m_cycle_q, m_cycle_d;
    logic [1:0] t_cycle_q, t_cycle_d;
    logic       cond_fail_q, cond_fail_d;
    logic       halted_q, halted_d;

    logic [3:0] len_base;
    logic [3:0] short_floor;
    logic [3:0] len_short;
    logic [3:0] len_eff;
    logic       last_m;
    logic       t3;
    logic       fetch_c;
    logic       halt_entry;

    // Effective instruction length. Widened to 4 bits so that cond+2 and the
    // comparison against MAX_MCYCLES never wrap.
    always_comb begin
        len_base    = {1'b0, sched_len};
        short_floor = {1'b0, sched_cond_mcycle} + 4'd2;
        len_short   = {1'b0, sched_short_len};
        if (len_base == 4'd0 || len_base > MAX_L) begin
            len_base = 4'd1;
        end
        // A failed condition can never end the instruction before the
        // M-cycle following the one that sampled it.
        if (len_short < short_floor) begin
            len_short = short_floor;
        end
        if (len_short > MAX_L) begin
            len_short = MAX_L;
        end
        len_eff = cond_fail_q ? len_short : len_base;
        last_m  = ({1'b0, m_cycle_q} == (len_eff - 4'd1));
        t3      = (t_cycle_q == T_LAST);
    end

    always_comb begin
        fetch_c = 1'b0;
        case (state_q)
            ST_RUN:    fetch_c = last_m;
            ST_PREFIX: fetch_c = 1'b1;
            ST_WAKE:   fetch_c = 1'b1;
            default:   fetch_c = 1'b0;
        endcase
        // A pending interrupt at the same T3 cancels the HALT request.
        halt_entry = (state_q == ST_RUN) && last_m && t3 && halt_req && !wake;
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        cb_prefix_d = cb_prefix_q;
        m_cycle_d   = m_cycle_q;
        cond_fail_d = cond_fail_q;
        halted_d    = halted_q;
        t_cycle_d   = t3 ? 2'd0 : t_cycle_q + 2'd1;

        if (t3) begin
            if (fetch_c) begin
                m_cycle_d   = 3'd0;
                cond_fail_d = 1'b0;
                if (halt_entry) begin
                    // The fetched byte is discarded; opcode stays as-is.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    opcode_d = data_in;
                    if (state_q == ST_PREFIX) begin
                        // Second byte of a CB instruction, even another 0xCB.
                        cb_prefix_d = 1'b1;
                        state_d     = ST_RUN;
                    end else if (data_in == CB_OP) begin
                        cb_prefix_d = 1'b0;
                        state_d     = ST_PREFIX;
                    end else begin
                        cb_prefix_d = 1'b0;
                        state_d     = ST_RUN;
                    end
                end
            end else if (state_q == ST_HALT) begin
                m_cycle_d = 3'd0;
                if (wake) begin
                    state_d  = ST_WAKE;
                    halted_d = 1'b0;
                end
            end else begin
                m_cycle_d = m_cycle_q + 3'd1;
                if (sched_cond_mcycle != 3'd0 && m_cycle_q == sched_cond_mcycle
                        && !cond_met) begin
                    cond_fail_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            opcode_q    <= 8'h00;
            cb_prefix_q <= 1'b0;
            m_cycle_q   <= 3'd0;
            t_cycle_q   <= 2'd0;
            cond_fail_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            cb_prefix_q <= cb_prefix_d;
            m_cycle_q   <= m_cycle_d;
            t_cycle_q   <= t_cycle_d;
            cond_fail_q <= cond_fail_d;
            halted_q    <= halted_d;
        end
    end

    assign opcode     = opcode_q;
    assign cb_prefix  = cb_prefix_q;
    assign m_cycle    = m_cycle_q;
    assign t_cycle    = t_cycle_q;
    assign fetch      = fetch_c;
    assign instr_done = fetch_c && t3;
    assign halted     = halted_q;

endmodule

// File: tb/tb_gb_cpu_mcycle_sequencer.sv
module tb_gb_cpu_mcycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [2:0] sched_len, sched_cond_mcycle, sched_short_len;
    logic       cond_met, halt_req, wake;
    logic [7:0] opcode;
    logic       cb_prefix;
    logic [2:0] m_cycle;
    logic [1:0] t_cycle;
    logic       fetch, instr_done, halted;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gb_cpu_mcycle_sequencer #(.MAX_MCYCLES(6), .TCYCLES_PER_M(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .sched_len(sched_len), .sched_cond_mcycle(sched_cond_mcycle),
        .sched_short_len(sched_short_len), .cond_met(cond_met),
        .halt_req(halt_req), .wake(wake), .opcode(opcode),
        .cb_prefix(cb_prefix), .m_cycle(m_cycle), .t_cycle(t_cycle),
        .fetch(fetch), .instr_done(instr_done), .halted(halted)
    );

    typedef struct {
        logic [2:0] len;
        logic [2:0] cnd;
        logic [2:0] shrt;
        logic       cmet;
        logic [7:0] din;
        int         clks;   // clks from first T0 through the done T3
        logic [2:0] lastm;  // m_cycle while instr_done is high
        logic [7:0] op;
        logic       cb;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clk and sample 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_sched(input logic [2:0] len, input logic [2:0] cnd,
                             input logic [2:0] shrt, input logic cmet);
        sched_len         = len;
        sched_cond_mcycle = cnd;
        sched_short_len   = shrt;
        cond_met          = cmet;
    endtask

    // Runs one instruction from its first T0 (caller is just after an edge).
    task automatic run_vec(input string name, input vec_t v);
        int clks = 0;
        int fcnt = 0;
        logic done = 1'b0;
        logic [2:0] lm = 3'd7;
        set_sched(v.len, v.cnd, v.shrt, v.cmet);
        data_in = v.din;
        #1;
        while (!done && clks < 64) begin
            if (fetch) fcnt++;
            if (instr_done) begin
                done = 1'b1;
                lm   = m_cycle;
            end
            step();
            clks++;
        end
        chk({name, ".clks"}, clks, v.clks);
        chk({name, ".fetch_clks"}, fcnt, 4);
        chk({name, ".last_m"}, {29'd0, lm}, {29'd0, v.lastm});
        chk({name, ".opcode"}, {24'd0, opcode}, {24'd0, v.op});
        chk({name, ".cb_prefix"}, {31'd0, cb_prefix}, {31'd0, v.cb});
        $display("%s: din=%02h clks=%0d last_m=%0d opcode=%02h cb=%0b",
                 name, v.din, clks, lm, opcode, cb_prefix);
    endtask

    initial begin
        int bad;
        //           len   cnd   shrt  cmet  din    clks lastm  op     cb
        vecs[0]  = '{3'd1, 3'd0, 3'd0, 1'b0, 8'h04, 4,  3'd0, 8'h04, 1'b0};
        vecs[1]  = '{3'd1, 3'd0, 3'd0, 1'b0, 8'h11, 4,  3'd0, 8'h11, 1'b0};
        vecs[2]  = '{3'd3, 3'd0, 3'd0, 1'b0, 8'h22, 12, 3'd2, 8'h22, 1'b0};
        vecs[3]  = '{3'd4, 3'd1, 3'd3, 1'b1, 8'h33, 16, 3'd3, 8'h33, 1'b0};
        vecs[4]  = '{3'd4, 3'd1, 3'd3, 1'b0, 8'h44, 12, 3'd2, 8'h44, 1'b0};
        vecs[5]  = '{3'd4, 3'd1, 3'd1, 1'b0, 8'h55, 12, 3'd2, 8'h55, 1'b0};
        vecs[6]  = '{3'd0, 3'd0, 3'd0, 1'b0, 8'h66, 4,  3'd0, 8'h66, 1'b0};
        vecs[7]  = '{3'd7, 3'd0, 3'd0, 1'b0, 8'h77, 4,  3'd0, 8'h77, 1'b0};
        vecs[8]  = '{3'd6, 3'd2, 3'd2, 1'b0, 8'h88, 16, 3'd3, 8'h88, 1'b0};
        vecs[9]  = '{3'd5, 3'd3, 3'd0, 1'b1, 8'h99, 20, 3'd4, 8'h99, 1'b0};
        vecs[10] = '{3'd1, 3'd0, 3'd0, 1'b0, 8'hCB, 4,  3'd0, 8'hCB, 1'b0};
        vecs[11] = '{3'd5, 3'd0, 3'd0, 1'b0, 8'h37, 4,  3'd0, 8'h37, 1'b1};
        vecs[12] = '{3'd1, 3'd0, 3'd0, 1'b0, 8'h00, 4,  3'd0, 8'h00, 1'b0};
        vecs[13] = '{3'd1, 3'd0, 3'd0, 1'b0, 8'hCB, 4,  3'd0, 8'hCB, 1'b0};
        vecs[14] = '{3'd1, 3'd0, 3'd0, 1'b0, 8'hCB, 4,  3'd0, 8'hCB, 1'b1};
        vecs[15] = '{3'd2, 3'd0, 3'd0, 1'b0, 8'h12, 8,  3'd1, 8'h12, 1'b0};
        vecs[16] = '{3'd2, 3'd0, 3'd1, 1'b0, 8'h13, 8,  3'd1, 8'h13, 1'b0};

        reset = 1'b1; data_in = 8'h00; halt_req = 1'b0; wake = 1'b0;
        set_sched(3'd1, 3'd0, 3'd0, 1'b0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst.opcode", {24'd0, opcode}, 32'h00);
        chk("rst.cb", {31'd0, cb_prefix}, 0);
        chk("rst.m", {29'd0, m_cycle}, 0);
        chk("rst.t", {30'd0, t_cycle}, 0);
        chk("rst.fetch", {31'd0, fetch}, 1);
        chk("rst.done", {31'd0, instr_done}, 0);
        chk("rst.halted", {31'd0, halted}, 0);
        $display("reset: opcode=%02h m=%0d t=%0d fetch=%0b", opcode, m_cycle, t_cycle, fetch);

        for (int i = 0; i < 17; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // HALT entry: byte on the bus is discarded, opcode 0x13 held.
        set_sched(3'd1, 3'd0, 3'd0, 1'b0);
        data_in = 8'hAA; halt_req = 1'b1;
        step(); step(); step();
        #1;
        chk("halt.done_pulse", {31'd0, instr_done}, 1);
        step();
        halt_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted !== 1'b1 || fetch !== 1'b0 || opcode !== 8'h13
                    || m_cycle !== 3'd0 || instr_done !== 1'b0) bad++;
            step();
        end
        chk("halt.hold20", bad, 0);
        chk("halt.t_after20", {30'd0, t_cycle}, 0);
        $display("halt: held 20 clks, opcode=%02h halted=%0b", opcode, halted);
        step();                    // t=1: raise wake mid-M-cycle
        wake = 1'b1; data_in = 8'h00;
        step();                    // t=2
        chk("wake.t2_halted", {31'd0, halted}, 1);
        step();                    // t=3
        chk("wake.t3_fetch", {31'd0, fetch}, 0);
        step();                    // WAKE M-cycle, t=0
        wake = 1'b0;
        #1;
        chk("wake.halted", {31'd0, halted}, 0);
        chk("wake.fetch", {31'd0, fetch}, 1);
        step(); step(); step();
        chk("wake.done", {31'd0, instr_done}, 1);
        step();
        chk("wake.opcode", {24'd0, opcode}, 32'h00);
        chk("wake.t0", {30'd0, t_cycle}, 0);
        $display("wake: opcode=%02h halted=%0b", opcode, halted);

        // HALT request with a pending interrupt at the same T3 is ignored.
        halt_req = 1'b1; wake = 1'b1;
        run_vec("halt_wake", '{3'd1, 3'd0, 3'd0, 1'b0, 8'h5A, 4, 3'd0, 8'h5A, 1'b0});
        chk("halt_wake.halted", {31'd0, halted}, 0);
        halt_req = 1'b0; wake = 1'b0;

        // Reset at m=2, t=1 of a conditional instruction whose condition failed.
        set_sched(3'd4, 3'd1, 3'd3, 1'b0);
        data_in = 8'h77;
        for (int i = 0; i < 9; i++) step();
        chk("midrst.pre_m", {29'd0, m_cycle}, 2);
        chk("midrst.pre_t", {30'd0, t_cycle}, 1);
        reset = 1'b1;
        set_sched(3'd1, 3'd0, 3'd0, 1'b1);
        step();
        reset = 1'b0;
        #1;
        chk("midrst.opcode", {24'd0, opcode}, 32'h00);
        chk("midrst.m", {29'd0, m_cycle}, 0);
        chk("midrst.t", {30'd0, t_cycle}, 0);
        chk("midrst.fetch", {31'd0, fetch}, 1);
        $display("mid-instr reset: opcode=%02h m=%0d t=%0d", opcode, m_cycle, t_cycle);
        // A stale cond_fail would cut this down to 12 clks.
        run_vec("postrst", '{3'd4, 3'd1, 3'd3, 1'b1, 8'h21, 16, 3'd3, 8'h21, 1'b0});

        // Reset while halted.
        halt_req = 1'b1;
        run_vec("halt2", '{3'd1, 3'd0, 3'd0, 1'b0, 8'hEE, 4, 3'd0, 8'h21, 1'b0});
        halt_req = 1'b0;
        step(); step(); step(); step(); step();
        chk("halt2.halted", {31'd0, halted}, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("haltrst.halted", {31'd0, halted}, 0);
        chk("haltrst.opcode", {24'd0, opcode}, 32'h00);
        chk("haltrst.fetch", {31'd0, fetch}, 1);
        chk("haltrst.t", {30'd0, t_cycle}, 0);
        chk("haltrst.m", {29'd0, m_cycle}, 0);
        $display("halt reset: halted=%0b opcode=%02h fetch=%0b", halted, opcode, fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
